instr_mem_param: RTL and testbench

Parametrised instruction memory for the single-cycle RISC-V core. It replaces the fixed 256x32 image with configurable depth and width, and adds a self-clearing sequence after reset. Loading is streamed with a valid/ready handshake and an auto-incrementing write pointer. Fetch uses a byte-addressed PC with a registered read port, and flags misaligned and out-of-range fetches.

---
 rtl/instr_mem_param.sv | 152 +++++++++++++++
 tb/tb_instr_mem_param.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_param.sv
// Parametrised instruction memory for the single-cycle RISC-V core.
// A power-up/reset CLEAR sequence zeroes the array one word per cycle. A
// valid/ready stream then loads the image through an auto-incrementing write
// pointer. Fetches use a byte PC, have one cycle of read latency, and return
// FAULT_INSTR with fault=1 when the PC is misaligned or beyond DEPTH words.
module instr_mem_param #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     DEPTH       = 256,
   parameter int unsigned     PC_W        = 32,
   parameter logic [XLEN-1:0] FAULT_INSTR = XLEN'(32'h00000013)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_en,
   input  logic                       load_valid,
   input  logic [XLEN-1:0]            load_inst,
   output logic                       load_ready,
   output logic                       load_done,
   output logic [$clog2(DEPTH+1)-1:0] load_count,
   output logic                       busy,
   input  logic                       rd_en,
   input  logic [PC_W-1:0]            pc,
   output logic [XLEN-1:0]            instruction,
   output logic                       instr_valid,
   output logic                       fault
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned IDX_W = PC_W - 2;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      LOAD,
      HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] count_d;
   logic             done_d;
   logic             mem_we;
   logic [XLEN-1:0]  mem_wdata;

   logic [XLEN-1:0]  mem [DEPTH];

   logic [IDX_W-1:0] rd_idx;
   logic             rd_fault;
   logic             fetch_ok;

   assign load_ready = (state_q == LOAD);
   assign busy       = (state_q == CLEAR);

   // Word index uses the full PC width, so large addresses never alias
   // back into the array; they are simply flagged as out of range.
   assign rd_idx   = pc[PC_W-1:2];
   assign rd_fault = (pc[1:0] != 2'b00) || (rd_idx >= IDX_W'(DEPTH));
   assign fetch_ok = rd_en && ((state_q == IDLE) || (state_q == HOLD));

   // Next-state logic: clear sweep, load entry/abort, and stream acceptance.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      count_d   = load_count;
      done_d    = load_done;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            if (ptr_q == LAST_PTR) begin
               ptr_d   = '0;
               state_d = IDLE;
            end else begin
               ptr_d = ptr_q + PTR_W'(1);
            end
         end
         IDLE: begin
            if (load_en) begin
               state_d = LOAD;
               ptr_d   = '0;
               count_d = '0;
               done_d  = 1'b0;
            end
         end
         LOAD: begin
            if (!load_en) begin
               state_d = IDLE;
            end else if (load_valid) begin
               mem_we    = 1'b1;
               mem_wdata = load_inst;
               count_d   = load_count + CNT_W'(1);
               if (ptr_q == LAST_PTR) begin
                  done_d  = 1'b1;
                  ptr_d   = '0;
                  state_d = HOLD;
               end else begin
                  ptr_d = ptr_q + PTR_W'(1);
               end
            end
         end
         HOLD: begin
            if (!load_en) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Control state register; reset always restarts the clear sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         ptr_q      <= '0;
         load_count <= '0;
         load_done  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         load_count <= count_d;
         load_done  <= done_d;
      end
   end

   // Storage array is cleared by the CLEAR sweep rather than by reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ptr_q] <= mem_wdata;
      end
   end

   // Registered read port; fault is a one-cycle qualifier of instr_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= '0;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
      end else begin
         instr_valid <= fetch_ok;
         fault       <= fetch_ok && rd_fault;
         if (fetch_ok) begin
            instruction <= rd_fault ? FAULT_INSTR : mem[rd_idx[PTR_W-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_param.sv
// Self-checking bench for instr_mem_param (default 256 x 32 configuration).
module tb_instr_mem_param;

   localparam int DEPTH = 256;

   logic        clk;
   logic        rst_n;
   logic        load_en;
   logic        load_valid;
   logic [31:0] load_inst;
   logic        load_ready;
   logic        load_done;
   logic [8:0]  load_count;
   logic        busy;
   logic        rd_en;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        fault;

   int tests_run;
   int tests_failed;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] last_instr;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_instr;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [10];

   instr_mem_param #(
      .XLEN(32),
      .DEPTH(DEPTH),
      .PC_W(32),
      .FAULT_INSTR(32'h00000013)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .load_en(load_en),
      .load_valid(load_valid),
      .load_inst(load_inst),
      .load_ready(load_ready),
      .load_done(load_done),
      .load_count(load_count),
      .busy(busy),
      .rd_en(rd_en),
      .pc(pc),
      .instruction(instruction),
      .instr_valid(instr_valid),
      .fault(fault)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference fetch: word index is pc/4, anything misaligned or past DEPTH faults.
   function automatic logic [32:0] ref_fetch(input logic [31:0] a);
      logic [31:0] idx;
      idx = a / 4;
      if ((a % 4) != 0 || idx >= DEPTH) return {1'b1, 32'h00000013};
      return {1'b0, model_mem[idx[7:0]]};
   endfunction

   task automatic apply_stimulus(input string name, input logic [31:0] a);
      logic [32:0] r;
      r     = ref_fetch(a);
      rd_en = 1'b1;
      pc    = a;
      step();
      rd_en = 1'b0;
      check_output({name, "_valid"}, 32'(instr_valid), 32'd1);
      check_output({name, "_instr"}, instruction, r[31:0]);
      check_output({name, "_fault"}, 32'(fault), 32'(r[32]));
      last_instr = r[31:0];
      step();
      check_output({name, "_pulse"}, 32'(instr_valid), 32'd0);
   endtask

   task automatic wait_clear(input string name);
      int n;
      logic stray;
      n     = 0;
      stray = 1'b0;
      rd_en = 1'b1;
      pc    = 32'h0;
      while (busy === 1'b1 && n < 1000) begin
         step();
         n++;
         if (instr_valid !== 1'b0) stray = 1'b1;
      end
      rd_en = 1'b0;
      check_output({name, "_busy_cycles"}, 32'(n), 32'd256);
      check_output({name, "_rd_ignored"}, 32'(stray), 32'd0);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
   endtask

   task automatic check_reset_values(input string name);
      check_output({name, "_busy"}, 32'(busy), 32'd1);
      check_output({name, "_ready"}, 32'(load_ready), 32'd0);
      check_output({name, "_done"}, 32'(load_done), 32'd0);
      check_output({name, "_count"}, 32'(load_count), 32'd0);
      check_output({name, "_valid"}, 32'(instr_valid), 32'd0);
      check_output({name, "_fault"}, 32'(fault), 32'd0);
      check_output({name, "_instr"}, instruction, 32'd0);
   endtask

   task automatic random_fetches(input string name, input int n);
      logic [32:0] r;
      logic [31:0] a;
      logic        req;
      for (int k = 0; k < n; k++) begin
         a     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         req   = ($urandom_range(0, 3) != 0);
         rd_en = req;
         pc    = a;
         r     = ref_fetch(a);
         step();
         if (req) begin
            check_output({name, "_valid"}, 32'(instr_valid), 32'd1);
            check_output({name, "_instr"}, instruction, r[31:0]);
            check_output({name, "_fault"}, 32'(fault), 32'(r[32]));
            last_instr = r[31:0];
         end else begin
            check_output({name, "_idle_valid"}, 32'(instr_valid), 32'd0);
            check_output({name, "_idle_fault"}, 32'(fault), 32'd0);
            check_output({name, "_hold_instr"}, instruction, last_instr);
         end
      end
      rd_en = 1'b0;
      step();
   endtask

   initial begin
      int   cyc;
      int   accepted;
      logic bad;
      logic [31:0] w;

      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      load_en      = 1'b0;
      load_valid   = 1'b0;
      load_inst    = 32'h0;
      rd_en        = 1'b0;
      pc           = 32'h0;
      last_instr   = 32'h0;

      vecs[0] = '{32'h00000000, 32'hDEADBE00, 1'b0};
      vecs[1] = '{32'h00000040, 32'hDEADBE10, 1'b0};
      vecs[2] = '{32'h000003FC, 32'hDEADBEFF, 1'b0};
      vecs[3] = '{32'h00000200, 32'hDEADBE80, 1'b0};
      vecs[4] = '{32'h00000041, 32'h00000013, 1'b1};
      vecs[5] = '{32'h00000400, 32'h00000013, 1'b1};
      vecs[6] = '{32'h00000044, 32'hDEADBE11, 1'b0};
      vecs[7] = '{32'h00000002, 32'h00000013, 1'b1};
      vecs[8] = '{32'hFFFFFFFC, 32'h00000013, 1'b1};
      vecs[9] = '{32'h000003F8, 32'hDEADBEFE, 1'b0};

      // Power-up reset and clear sweep.
      #12;
      check_reset_values("por");
      step();
      rst_n = 1'b1;
      wait_clear("por");
      apply_stimulus("fetch_zero", 32'h0);

      // Full load with load_valid held high.
      load_en = 1'b1;
      step();
      check_output("load_ready_on", 32'(load_ready), 32'd1);
      check_output("load_count_start", 32'(load_count), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         load_valid = 1'b1;
         load_inst  = {24'hDEADBE, 8'(i)};
         model_mem[i] = load_inst;
         step();
         if (i == DEPTH - 2) begin
            check_output("done_before_last", 32'(load_done), 32'd0);
            check_output("count_before_last", 32'(load_count), 32'd255);
         end
      end
      load_valid = 1'b0;
      check_output("done_full", 32'(load_done), 32'd1);
      check_output("count_full", 32'(load_count), 32'd256);
      check_output("ready_after_full", 32'(load_ready), 32'd0);
      step();
      step();
      check_output("hold_ready", 32'(load_ready), 32'd0);
      check_output("hold_count", 32'(load_count), 32'd256);
      apply_stimulus("fetch_in_hold", 32'h3FC);
      load_en = 1'b0;
      step();
      check_output("done_sticky", 32'(load_done), 32'd1);

      // Table of fetches, issued back to back.
      rd_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pc = vecs[i].pc;
         step();
         check_output($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'd1);
         check_output($sformatf("vec%0d_instr", i), instruction, vecs[i].exp_instr);
         check_output($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
         last_instr = vecs[i].exp_instr;
      end
      rd_en = 1'b0;
      step();
      check_output("vec_end_valid", 32'(instr_valid), 32'd0);
      check_output("vec_end_hold", instruction, last_instr);

      // Reload with load_valid toggling and random words.
      load_en = 1'b1;
      step();
      check_output("reload_done_clr", 32'(load_done), 32'd0);
      check_output("reload_count_clr", 32'(load_count), 32'd0);
      accepted = 0;
      cyc      = 0;
      bad      = 1'b0;
      while (accepted < DEPTH && cyc < 1000) begin
         load_valid = ((cyc % 2) == 0);
         w          = $urandom;
         load_inst  = w;
         step();
         if (load_valid) begin
            model_mem[accepted] = w;
            accepted++;
         end
         if (load_count !== 9'(accepted)) bad = 1'b1;
         if (accepted < DEPTH && load_done !== 1'b0) bad = 1'b1;
         cyc++;
      end
      load_valid = 1'b0;
      check_output("gap_count_track", 32'(bad), 32'd0);
      check_output("gap_cycles", 32'(cyc), 32'd511);
      check_output("gap_done", 32'(load_done), 32'd1);
      load_en = 1'b0;
      step();
      random_fetches("rnd_a", 60);

      // Reset in the middle of a load.
      load_en = 1'b1;
      step();
      load_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         load_inst = $urandom;
         step();
      end
      check_output("mid_count", 32'(load_count), 32'd100);
      rst_n = 1'b0;
      #2;
      check_reset_values("mid_rst");
      load_en    = 1'b0;
      load_valid = 1'b0;
      step();
      rst_n = 1'b1;
      wait_clear("mid_rst");
      apply_stimulus("fetch_after_clr", 32'h0);

      // Abort after ten words; fetch requests during LOAD are ignored.
      load_en = 1'b1;
      step();
      rd_en = 1'b1;
      pc    = 32'h0;
      bad   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         load_valid   = 1'b1;
         w            = $urandom | 32'h1;
         load_inst    = w;
         model_mem[i] = w;
         step();
         if (instr_valid !== 1'b0 || instruction !== last_instr) bad = 1'b1;
      end
      check_output("rd_in_load", 32'(bad), 32'd0);
      load_en   = 1'b0;
      load_inst = 32'hA5A5A5A5;
      step();
      rd_en      = 1'b0;
      load_valid = 1'b0;
      check_output("abort_valid", 32'(instr_valid), 32'd0);
      check_output("abort_ready", 32'(load_ready), 32'd0);
      check_output("abort_done", 32'(load_done), 32'd0);
      check_output("abort_count", 32'(load_count), 32'd10);
      step();
      apply_stimulus("abort_word9", 32'h24);
      apply_stimulus("abort_word10", 32'h28);
      random_fetches("rnd_b", 40);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
